// File: rtl/line_raster_engine_if.sv
// rtl/line_raster_engine_if.sv - command, memory-port and status bundle for line_raster_engine
// Ports (all signals, grouped by direction seen from the engine):
//   command in  : cmd_valid, cmd_x0/y0/x1/y1 (signed COORD_W), cmd_color (BPP), cmd_mode (2), fb_base (ADDR_W)
//   command out : cmd_ready
//   memory out  : mem_req, mem_we, mem_addr (ADDR_W), mem_wdata (32)
//   memory in   : mem_ready, mem_rvalid, mem_rdata (32)
//   status out  : busy, done, pixels_drawn, pixels_clipped (COORD_W+1)
// modport slave is the engine view, modport master is the host/memory view.
interface line_raster_engine_if #(
  parameter int BPP     = 1,
  parameter int COORD_W = 16,
  parameter int ADDR_W  = 32
) ();
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic signed [COORD_W-1:0] cmd_x0;
  logic signed [COORD_W-1:0] cmd_y0;
  logic signed [COORD_W-1:0] cmd_x1;
  logic signed [COORD_W-1:0] cmd_y1;
  logic [BPP-1:0]            cmd_color;
  logic [1:0]                cmd_mode;
  logic [ADDR_W-1:0]         fb_base;
  logic                      mem_req;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [31:0]               mem_wdata;
  logic                      mem_ready;
  logic                      mem_rvalid;
  logic [31:0]               mem_rdata;
  logic                      busy;
  logic                      done;
  logic [COORD_W:0]          pixels_drawn;
  logic [COORD_W:0]          pixels_clipped;

  modport slave (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, cmd_mode, fb_base,
    output cmd_ready,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output busy, done, pixels_drawn, pixels_clipped
  );

  modport master (
    output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, cmd_mode, fb_base,
    input  cmd_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  busy, done, pixels_drawn, pixels_clipped
  );
endinterface

// File: rtl/line_raster_engine.sv
// rtl/line_raster_engine.sv - Bresenham line rasterizer with clipping and coalesced framebuffer read-modify-write
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : line_raster_engine_if.slave (command handshake, word memory port, status/counters)
// One command at a time. Pixels falling in the currently held framebuffer word are
// merged without touching memory; the held word is written back only when the line
// leaves it (or at the end of the line).
module line_raster_engine #(
  parameter int FB_WIDTH  = 64,
  parameter int FB_HEIGHT = 64,
  parameter int BPP       = 1,
  parameter int COORD_W   = 16,
  parameter int ADDR_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  line_raster_engine_if.slave  bus
);

  localparam int PPW       = 32 / BPP;
  localparam int ROW_WORDS = FB_WIDTH / PPW;
  localparam int EW        = COORD_W + 2;
  localparam logic [31:0] FMASK = (BPP == 32) ? 32'hFFFF_FFFF : ((32'd1 << BPP) - 32'd1);

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_STEP, S_WRITE, S_READ, S_RWAIT, S_MODIFY, S_FLUSH, S_DONE
  } state_t;

  state_t                    state_q;
  logic signed [COORD_W-1:0] cur_x_q, cur_y_q, x1_q, y1_q;
  logic [BPP-1:0]            color_q;
  logic [1:0]                mode_q;
  logic [ADDR_W-1:0]         base_q;
  logic signed [EW-1:0]      dx_q, dy_q, err_q;
  logic                      sx_neg_q, sy_neg_q;
  logic [31:0]               held_q;
  logic [ADDR_W-1:0]         held_addr_q;
  logic                      held_valid_q, dirty_q;
  logic                      cmd_ready_q, mem_req_q, mem_we_q, busy_q, done_q;
  logic [ADDR_W-1:0]         mem_addr_q;
  logic [31:0]               mem_wdata_q;
  logic [COORD_W:0]          drawn_q, clipped_q;

  // SETUP arithmetic
  logic signed [EW-1:0] xdiff, ydiff, abs_dx, abs_dy;
  always_comb begin
    xdiff  = EW'(x1_q) - EW'(cur_x_q);
    ydiff  = EW'(y1_q) - EW'(cur_y_q);
    abs_dx = xdiff[EW-1] ? -xdiff : xdiff;
    abs_dy = ydiff[EW-1] ? -ydiff : ydiff;
  end

  // Next Bresenham position; e2 gets one extra bit so 2*err cannot overflow
  logic signed [EW:0]        e2;
  logic                      step_x, step_y;
  logic signed [EW-1:0]      err_d;
  logic signed [COORD_W-1:0] x_d, y_d;
  always_comb begin
    e2     = $signed({err_q, 1'b0});
    step_x = (e2 >= (EW+1)'(dy_q));
    step_y = (e2 <= (EW+1)'(dx_q));
    err_d  = err_q;
    x_d    = cur_x_q;
    y_d    = cur_y_q;
    if (step_x) begin
      err_d = err_d + dy_q;
      x_d   = sx_neg_q ? (cur_x_q - COORD_W'(1)) : (cur_x_q + COORD_W'(1));
    end
    if (step_y) begin
      err_d = err_d + dx_q;
      y_d   = sy_neg_q ? (cur_y_q - COORD_W'(1)) : (cur_y_q + COORD_W'(1));
    end
  end

  // Current pixel: bounds, word address, field position and merged word
  logic              in_bounds, at_end;
  logic [ADDR_W-1:0] x_a, y_a, word_idx, pix_addr;
  logic [4:0]        bit_off;
  logic [31:0]       col_w, mask_w, new_word;
  always_comb begin
    in_bounds = !cur_x_q[COORD_W-1] && !cur_y_q[COORD_W-1] &&
                ($unsigned(cur_x_q) < COORD_W'(FB_WIDTH)) &&
                ($unsigned(cur_y_q) < COORD_W'(FB_HEIGHT));
    at_end    = (cur_x_q == x1_q) && (cur_y_q == y1_q);
    x_a       = ADDR_W'($unsigned(cur_x_q));
    y_a       = ADDR_W'($unsigned(cur_y_q));
    word_idx  = y_a * ADDR_W'(ROW_WORDS) + x_a / ADDR_W'(PPW);
    pix_addr  = base_q + (word_idx << 2);
    bit_off   = 5'((x_a % ADDR_W'(PPW)) * ADDR_W'(BPP));
    col_w     = 32'(color_q) << bit_off;
    mask_w    = FMASK << bit_off;
    case (mode_q)
      2'b00:   new_word = (held_q & ~mask_w) | col_w;
      2'b01:   new_word = held_q | col_w;
      2'b10:   new_word = held_q ^ col_w;
      default: new_word = held_q & ~col_w;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
      color_q      <= '0;
      mode_q       <= '0;
      base_q       <= '0;
      dx_q         <= '0;
      dy_q         <= '0;
      err_q        <= '0;
      sx_neg_q     <= 1'b0;
      sy_neg_q     <= 1'b0;
      held_q       <= '0;
      held_addr_q  <= '0;
      held_valid_q <= 1'b0;
      dirty_q      <= 1'b0;
      cmd_ready_q  <= 1'b1;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      drawn_q      <= '0;
      clipped_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            cur_x_q      <= bus.cmd_x0;
            cur_y_q      <= bus.cmd_y0;
            x1_q         <= bus.cmd_x1;
            y1_q         <= bus.cmd_y1;
            color_q      <= bus.cmd_color;
            mode_q       <= bus.cmd_mode;
            base_q       <= bus.fb_base;
            drawn_q      <= '0;
            clipped_q    <= '0;
            held_valid_q <= 1'b0;
            dirty_q      <= 1'b0;
            cmd_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= S_SETUP;
          end
        end
        S_SETUP: begin
          dx_q     <= abs_dx;
          dy_q     <= -abs_dy;
          err_q    <= abs_dx - abs_dy;
          sx_neg_q <= (x1_q < cur_x_q);
          sy_neg_q <= (y1_q < cur_y_q);
          state_q  <= S_STEP;
        end
        S_STEP: begin
          if (!in_bounds) begin
            clipped_q <= clipped_q + (COORD_W+1)'(1);
            if (at_end) begin
              state_q <= S_FLUSH;
            end else begin
              cur_x_q <= x_d;
              cur_y_q <= y_d;
              err_q   <= err_d;
            end
          end else if (held_valid_q && (pix_addr == held_addr_q)) begin
            state_q <= S_MODIFY;
          end else if (dirty_q) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= held_addr_q;
            mem_wdata_q <= held_q;
            state_q     <= S_WRITE;
          end else begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= pix_addr;
            state_q    <= S_READ;
          end
        end
        S_WRITE: begin
          // write-back accepted: keep mem_req high and turn it into the read
          if (bus.mem_ready) begin
            dirty_q    <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= pix_addr;
            state_q    <= S_READ;
          end
        end
        S_READ: begin
          if (bus.mem_ready) begin
            mem_req_q <= 1'b0;
            state_q   <= S_RWAIT;
          end
        end
        S_RWAIT: begin
          if (bus.mem_rvalid) begin
            held_q       <= bus.mem_rdata;
            held_addr_q  <= mem_addr_q;
            held_valid_q <= 1'b1;
            state_q      <= S_MODIFY;
          end
        end
        S_MODIFY: begin
          held_q  <= new_word;
          dirty_q <= 1'b1;
          drawn_q <= drawn_q + (COORD_W+1)'(1);
          if (at_end) begin
            state_q <= S_FLUSH;
          end else begin
            cur_x_q <= x_d;
            cur_y_q <= y_d;
            err_q   <= err_d;
            state_q <= S_STEP;
          end
        end
        S_FLUSH: begin
          if (mem_req_q) begin
            if (bus.mem_ready) begin
              mem_req_q <= 1'b0;
              mem_we_q  <= 1'b0;
              dirty_q   <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= S_DONE;
            end
          end else if (dirty_q) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= held_addr_q;
            mem_wdata_q <= held_q;
          end else begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready      = cmd_ready_q;
  assign bus.mem_req        = mem_req_q;
  assign bus.mem_we         = mem_we_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_wdata      = mem_wdata_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pixels_drawn   = drawn_q;
  assign bus.pixels_clipped = clipped_q;

endmodule

// File: tb/tb_line_raster_engine.sv
// tb/tb_line_raster_engine.sv - self-checking bench for line_raster_engine
module tb_line_raster_engine;
  localparam int CW = 16;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  line_raster_engine_if #(.BPP(1), .COORD_W(CW), .ADDR_W(AW)) bus0 ();
  line_raster_engine_if #(.BPP(4), .COORD_W(CW), .ADDR_W(AW)) bus1 ();

  line_raster_engine #(.FB_WIDTH(64), .FB_HEIGHT(64), .BPP(1), .COORD_W(CW), .ADDR_W(AW))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  line_raster_engine #(.FB_WIDTH(64), .FB_HEIGHT(64), .BPP(4), .COORD_W(CW), .ADDR_W(AW))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int vectors = 0;
  int miscompares = 0;

  bit [31:0] mem0 [bit [31:0]];
  bit [31:0] ref0 [bit [31:0]];
  bit [31:0] mem1 [bit [31:0]];
  int n_rd0 = 0, n_wr0 = 0, done0 = 0, stab0 = 0, force_stall0 = 0, done1 = 0;
  bit req_seen0 = 0;

  function automatic bit [31:0] rd_mem0(input bit [31:0] a);
    if (mem0.exists(a)) return mem0[a];
    return 32'd0;
  endfunction
  function automatic bit [31:0] rd_ref0(input bit [31:0] a);
    if (ref0.exists(a)) return ref0[a];
    return 32'd0;
  endfunction
  function automatic bit [31:0] rd_mem1(input bit [31:0] a);
    if (mem1.exists(a)) return mem1[a];
    return 32'd0;
  endfunction

  // Memory for dut0: random ready, read data 1..3 cycles after acceptance, hold checks while stalled
  bit p_req0, p_we0, p_rdy0;
  bit [31:0] p_addr0, p_wdata0, rd_addr0;
  int rd_cnt0;
  always @(negedge clk) begin
    if (!rst_n) begin
      p_req0 = 0; p_rdy0 = 0; rd_cnt0 = 0;
      bus0.mem_ready = 0; bus0.mem_rvalid = 0; bus0.mem_rdata = 0;
    end else begin
      if (bus0.done) done0++;
      if (bus0.mem_req) req_seen0 = 1;
      bus0.mem_rvalid = 0;
      if (rd_cnt0 > 0) begin
        rd_cnt0--;
        if (rd_cnt0 == 0) begin bus0.mem_rvalid = 1; bus0.mem_rdata = rd_mem0(rd_addr0); end
      end
      if (p_req0 && p_rdy0) begin
        if (p_we0) begin mem0[p_addr0] = p_wdata0; n_wr0++; end
        else begin rd_addr0 = p_addr0; rd_cnt0 = $urandom_range(1, 3); n_rd0++; end
      end else if (p_req0) begin
        vectors++; stab0++;
        if (bus0.mem_req !== 1'b1 || bus0.mem_addr !== p_addr0 || bus0.mem_we !== p_we0 ||
            (p_we0 && bus0.mem_wdata !== p_wdata0)) begin
          miscompares++;
          $display("FAIL mem_hold: req=%b addr=%h we=%b wdata=%h, required req=1 addr=%h we=%b wdata=%h",
                   bus0.mem_req, bus0.mem_addr, bus0.mem_we, bus0.mem_wdata, p_addr0, p_we0, p_wdata0);
        end
      end
      if (force_stall0 > 0 && bus0.mem_req) begin bus0.mem_ready = 0; force_stall0--; end
      else bus0.mem_ready = ($urandom_range(0, 3) != 0);
      p_req0 = bus0.mem_req; p_we0 = bus0.mem_we; p_addr0 = bus0.mem_addr;
      p_wdata0 = bus0.mem_wdata; p_rdy0 = bus0.mem_ready;
    end
  end

  // Memory for dut1: always ready, read data the cycle after acceptance
  bit p_req1, p_we1, rd_pend1;
  bit [31:0] p_addr1, p_wdata1, rd_addr1;
  always @(negedge clk) begin
    if (!rst_n) begin
      p_req1 = 0; rd_pend1 = 0;
      bus1.mem_ready = 0; bus1.mem_rvalid = 0; bus1.mem_rdata = 0;
    end else begin
      if (bus1.done) done1++;
      bus1.mem_rvalid = 0;
      if (rd_pend1) begin bus1.mem_rvalid = 1; bus1.mem_rdata = rd_mem1(rd_addr1); rd_pend1 = 0; end
      if (p_req1) begin
        if (p_we1) mem1[p_addr1] = p_wdata1;
        else begin rd_addr1 = p_addr1; rd_pend1 = 1; end
      end
      bus1.mem_ready = 1;
      p_req1 = bus1.mem_req; p_we1 = bus1.mem_we; p_addr1 = bus1.mem_addr; p_wdata1 = bus1.mem_wdata;
    end
  end

  // Reference: plain Bresenham plotting single pixels into ref0 (BPP=1, 64x64, 2 words per row)
  function automatic void model_line0(input int x0, y0, x1, y1, color, mode, input bit [31:0] base,
                                      output int drawn, output int clip);
    int dx, dy, sx, sy, err, e2, x, y, b;
    bit [31:0] a, w;
    bit f, c;
    dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy = -((y1 > y0) ? y1 - y0 : y0 - y1);
    sx = (x0 < x1) ? 1 : -1;
    sy = (y0 < y1) ? 1 : -1;
    err = dx + dy; x = x0; y = y0; drawn = 0; clip = 0;
    for (int n = 0; n < 100000; n++) begin
      if (x >= 0 && x < 64 && y >= 0 && y < 64) begin
        a = base + 32'((y * 2 + x / 32) * 4);
        b = x % 32;
        w = rd_ref0(a); f = w[b]; c = color[0];
        case (mode)
          0: f = c;
          1: f = f | c;
          2: f = f ^ c;
          default: f = f & ~c;
        endcase
        w[b] = f; ref0[a] = w; drawn++;
      end else clip++;
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endfunction

  function automatic int fb_diff0(input bit [31:0] base, output bit [31:0] first);
    int n = 0;
    first = 0;
    for (int i = 0; i < 128; i++) begin
      bit [31:0] a = base + 32'(i * 4);
      if (rd_mem0(a) !== rd_ref0(a)) begin
        if (n == 0) first = a;
        n++;
      end
    end
    return n;
  endfunction

  task automatic drive_cmd0(input int x0, y0, x1, y1, color, mode, input bit [31:0] base);
    bus0.cmd_x0 = CW'(x0); bus0.cmd_y0 = CW'(y0); bus0.cmd_x1 = CW'(x1); bus0.cmd_y1 = CW'(y1);
    bus0.cmd_color = 1'(color); bus0.cmd_mode = 2'(mode); bus0.fb_base = base;
    bus0.cmd_valid = 1;
  endtask

  task automatic wait_done0(input string name);
    int t = 0;
    while (bus0.done !== 1'b1 && t < 8000) begin @(negedge clk); t++; end
    vectors++;
    if (bus0.done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_done: done=%b after %0d cycles, required 1", name, bus0.done, t);
    end
    @(negedge clk);
  endtask

  task automatic run_cmd0(input string name, input int x0, y0, x1, y1, color, mode,
                          input bit [31:0] base, output int m_drawn, output int m_clip);
    int t = 0;
    model_line0(x0, y0, x1, y1, color, mode, base, m_drawn, m_clip);
    while (bus0.cmd_ready !== 1'b1 && t < 3000) begin @(negedge clk); t++; end
    drive_cmd0(x0, y0, x1, y1, color, mode, base);
    @(negedge clk);
    bus0.cmd_valid = 0;
    wait_done0(name);
  endtask

  task automatic run_cmd1(input int x, y, color, mode);
    int t = 0;
    while (bus1.cmd_ready !== 1'b1 && t < 3000) begin @(negedge clk); t++; end
    bus1.cmd_x0 = CW'(x); bus1.cmd_y0 = CW'(y); bus1.cmd_x1 = CW'(x); bus1.cmd_y1 = CW'(y);
    bus1.cmd_color = 4'(color); bus1.cmd_mode = 2'(mode); bus1.fb_base = 32'h0;
    bus1.cmd_valid = 1;
    @(negedge clk);
    bus1.cmd_valid = 0;
    t = 0;
    while (bus1.done !== 1'b1 && t < 3000) begin @(negedge clk); t++; end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0;
    #1;
    vectors++;
    if (bus0.cmd_ready !== 1'b1 || bus0.busy !== 1'b0 || bus0.done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: ready=%b busy=%b done=%b, required 1 0 0", bus0.cmd_ready, bus0.busy, bus0.done);
    end
    vectors++;
    if (bus0.mem_req !== 1'b0 || bus0.mem_we !== 1'b0 || bus0.mem_addr !== 32'h0 || bus0.mem_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mem: req=%b we=%b addr=%h wdata=%h, required all zero",
               bus0.mem_req, bus0.mem_we, bus0.mem_addr, bus0.mem_wdata);
    end
    vectors++;
    if (bus0.pixels_drawn !== 17'd0 || bus0.pixels_clipped !== 17'd0) begin
      miscompares++;
      $display("FAIL reset_cnt: drawn=%0d clipped=%0d, required 0 0", bus0.pixels_drawn, bus0.pixels_clipped);
    end
    do_reset();
  endtask

  task automatic test_hline();
    int d, c, r0, w0;
    mem0.delete(); ref0.delete();
    r0 = n_rd0; w0 = n_wr0;
    run_cmd0("hline", 16, 16, 47, 16, 1, 1, 32'h2000, d, c);
    vectors++;
    if (rd_mem0(32'h2080) !== 32'hFFFF0000 || rd_mem0(32'h2084) !== 32'h0000FFFF) begin
      miscompares++;
      $display("FAIL hline_words: %h %h, required FFFF0000 0000FFFF", rd_mem0(32'h2080), rd_mem0(32'h2084));
    end
    vectors++;
    if (n_rd0 - r0 != 2 || n_wr0 - w0 != 2) begin
      miscompares++;
      $display("FAIL hline_accesses: reads=%0d writes=%0d, required 2 2", n_rd0 - r0, n_wr0 - w0);
    end
    vectors++;
    if (bus0.pixels_drawn !== 17'd32) begin
      miscompares++;
      $display("FAIL hline_drawn: %0d, required 32", bus0.pixels_drawn);
    end
  endtask

  task automatic test_point();
    int d, c, d0;
    mem0.delete(); ref0.delete();
    d0 = done0;
    run_cmd0("point", 5, 5, 5, 5, 1, 1, 32'h2000, d, c);
    repeat (3) @(negedge clk);
    vectors++;
    if (rd_mem0(32'h2028) !== 32'h00000020) begin
      miscompares++;
      $display("FAIL point_word: %h, required 00000020", rd_mem0(32'h2028));
    end
    vectors++;
    if (done0 - d0 != 1 || bus0.pixels_drawn !== 17'd1) begin
      miscompares++;
      $display("FAIL point_done: pulses=%0d drawn=%0d, required 1 1", done0 - d0, bus0.pixels_drawn);
    end
  endtask

  task automatic test_clip();
    int d, c, d0;
    mem0.delete(); ref0.delete();
    run_cmd0("clip_edge", 60, 10, 70, 10, 1, 1, 32'h2000, d, c);
    vectors++;
    if (rd_mem0(32'h2054) !== 32'hF0000000 || bus0.pixels_drawn !== 17'd4 || bus0.pixels_clipped !== 17'd7) begin
      miscompares++;
      $display("FAIL clip_edge: word=%h drawn=%0d clipped=%0d, required F0000000 4 7",
               rd_mem0(32'h2054), bus0.pixels_drawn, bus0.pixels_clipped);
    end
    req_seen0 = 0; d0 = done0;
    run_cmd0("clip_all", -5, -5, -1, -1, 1, 1, 32'h2000, d, c);
    vectors++;
    if (req_seen0 !== 1'b0 || done0 - d0 != 1 || bus0.pixels_drawn !== 17'd0 || bus0.pixels_clipped !== 17'd5) begin
      miscompares++;
      $display("FAIL clip_all: req_seen=%b pulses=%0d drawn=%0d clipped=%0d, required 0 1 0 5",
               req_seen0, done0 - d0, bus0.pixels_drawn, bus0.pixels_clipped);
    end
  endtask

  task automatic test_xor_twice();
    int d, c;
    mem0.delete(); ref0.delete();
    run_cmd0("xor1", 0, 0, 3, 3, 1, 2, 32'h2000, d, c);
    vectors++;
    if (rd_mem0(32'h2000) !== 32'h1 || rd_mem0(32'h2008) !== 32'h2 ||
        rd_mem0(32'h2010) !== 32'h4 || rd_mem0(32'h2018) !== 32'h8) begin
      miscompares++;
      $display("FAIL xor_first: %h %h %h %h, required 1 2 4 8", rd_mem0(32'h2000), rd_mem0(32'h2008),
               rd_mem0(32'h2010), rd_mem0(32'h2018));
    end
    run_cmd0("xor2", 0, 0, 3, 3, 1, 2, 32'h2000, d, c);
    vectors++;
    if ((rd_mem0(32'h2000) | rd_mem0(32'h2008) | rd_mem0(32'h2010) | rd_mem0(32'h2018)) !== 32'h0) begin
      miscompares++;
      $display("FAIL xor_second: %h %h %h %h, required all 0", rd_mem0(32'h2000), rd_mem0(32'h2008),
               rd_mem0(32'h2010), rd_mem0(32'h2018));
    end
  endtask

  task automatic test_bpp4();
    mem1.delete();
    mem1[32'h0] = 32'hFFFFFFFF;
    run_cmd1(3, 0, 4'hA, 0);
    vectors++;
    if (rd_mem1(32'h0) !== 32'hFFFFAFFF) begin
      miscompares++;
      $display("FAIL bpp4_replace: %h, required FFFFAFFF", rd_mem1(32'h0));
    end
    run_cmd1(3, 0, 4'hF, 3);
    vectors++;
    if (rd_mem1(32'h0) !== 32'hFFFF0FFF) begin
      miscompares++;
      $display("FAIL bpp4_clear: %h, required FFFF0FFF", rd_mem1(32'h0));
    end
  endtask

  task automatic test_random();
    int d, c, nd;
    bit [31:0] fa;
    mem0.delete(); ref0.delete();
    for (int i = 0; i < 128; i++) begin
      bit [31:0] w = $urandom;
      mem0[32'h2000 + 32'(i * 4)] = w;
      ref0[32'h2000 + 32'(i * 4)] = w;
    end
    for (int k = 0; k < 24; k++) begin
      int x0 = int'($urandom_range(0, 79)) - 8, y0 = int'($urandom_range(0, 79)) - 8;
      int x1 = int'($urandom_range(0, 79)) - 8, y1 = int'($urandom_range(0, 79)) - 8;
      run_cmd0("rand", x0, y0, x1, y1, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 32'h2000, d, c);
      vectors++;
      if (bus0.pixels_drawn !== 17'(d) || bus0.pixels_clipped !== 17'(c)) begin
        miscompares++;
        $display("FAIL rand_counts (%0d,%0d)->(%0d,%0d): drawn=%0d clipped=%0d, required %0d %0d",
                 x0, y0, x1, y1, bus0.pixels_drawn, bus0.pixels_clipped, d, c);
      end
      nd = fb_diff0(32'h2000, fa);
      vectors++;
      if (nd != 0) begin
        miscompares++;
        $display("FAIL rand_fb (%0d,%0d)->(%0d,%0d): %0d words differ, word %h is %h, required %h",
                 x0, y0, x1, y1, nd, fa, rd_mem0(fa), rd_ref0(fa));
      end
    end
  endtask

  task automatic test_stall();
    int d, c, s0;
    mem0.delete(); ref0.delete();
    s0 = stab0;
    force_stall0 = 5;
    run_cmd0("stall", 9, 3, 9, 3, 1, 1, 32'h2000, d, c);
    vectors++;
    if (stab0 - s0 < 5 || rd_mem0(32'h2018) !== 32'h00000200) begin
      miscompares++;
      $display("FAIL stall: hold_checks=%0d word=%h, required >=5 and 00000200", stab0 - s0, rd_mem0(32'h2018));
    end
  endtask

  task automatic test_back_to_back();
    int da, ca, db, cb, d0, t, nd;
    bit [31:0] fa;
    mem0.delete(); ref0.delete();
    d0 = done0;
    model_line0(2, 40, 50, 44, 1, 1, 32'h2000, da, ca);
    model_line0(10, 30, 12, 60, 1, 2, 32'h2000, db, cb);
    drive_cmd0(2, 40, 50, 44, 1, 1, 32'h2000);
    @(negedge clk);
    drive_cmd0(10, 30, 12, 60, 1, 2, 32'h2000);
    @(negedge clk);
    vectors++;
    if (bus0.cmd_ready !== 1'b0 || bus0.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_busy: ready=%b busy=%b, required 0 1", bus0.cmd_ready, bus0.busy);
    end
    t = 0;
    while (done0 - d0 < 1 && t < 8000) begin @(negedge clk); t++; end
    t = 0;
    while (bus0.cmd_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    @(negedge clk);
    bus0.cmd_valid = 0;
    wait_done0("b2b");
    nd = fb_diff0(32'h2000, fa);
    vectors++;
    if (nd != 0 || done0 - d0 != 2 || bus0.pixels_drawn !== 17'(db)) begin
      miscompares++;
      $display("FAIL b2b_result: diff_words=%0d pulses=%0d drawn=%0d, required 0 2 %0d", nd, done0 - d0, bus0.pixels_drawn, db);
    end
  endtask

  task automatic test_reset_mid();
    int t = 0, d, c;
    mem0.delete(); ref0.delete();
    drive_cmd0(0, 0, 63, 40, 1, 1, 32'h2000);
    @(negedge clk);
    bus0.cmd_valid = 0;
    while (bus0.mem_req !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    rst_n = 0;
    #1;
    vectors++;
    if (bus0.mem_req !== 1'b0 || bus0.busy !== 1'b0 || bus0.cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid: req=%b busy=%b ready=%b, required 0 0 1", bus0.mem_req, bus0.busy, bus0.cmd_ready);
    end
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    mem0.delete(); ref0.delete();
    run_cmd0("after_reset", 40, 63, 40, 63, 1, 1, 32'h2000, d, c);
    vectors++;
    if (rd_mem0(32'h21FC) !== 32'h00000100 || bus0.pixels_drawn !== 17'd1) begin
      miscompares++;
      $display("FAIL after_reset: word=%h drawn=%0d, required 00000100 1", rd_mem0(32'h21FC), bus0.pixels_drawn);
    end
  endtask

  initial begin
    bus0.cmd_valid = 0; bus0.cmd_x0 = 0; bus0.cmd_y0 = 0; bus0.cmd_x1 = 0; bus0.cmd_y1 = 0;
    bus0.cmd_color = 0; bus0.cmd_mode = 0; bus0.fb_base = 0;
    bus1.cmd_valid = 0; bus1.cmd_x0 = 0; bus1.cmd_y0 = 0; bus1.cmd_x1 = 0; bus1.cmd_y1 = 0;
    bus1.cmd_color = 0; bus1.cmd_mode = 0; bus1.fb_base = 0;
    @(negedge clk);
    test_reset();
    test_hline();
    test_point();
    test_clip();
    test_xor_twice();
    test_bpp4();
    test_random();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
